// File: rtl/data_mem_ctrl.sv
// Data memory stage with valid/ready request/response handshake.
// Byte/half/word access, fixed access latency, one transaction in flight.
module data_mem_ctrl #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  mem_t mem = init_mem();

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        wr_q, uns_q;
  logic [1:0]  sz_q;
  logic [31:0] addr_q, wd_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, fire;
  logic        c_wr, c_uns, c_err, c_ok;
  logic [1:0]  c_sz;
  logic [31:0] c_addr, c_wd;
  logic [IW-1:0] idx;
  logic [31:0] word, ld, wr_word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign accept = (state_q == IDLE) && req_valid;
  assign fire   = ((state_q == WAIT) && (cnt_q == 4'd0))
               || (accept && (LATENCY == 1));

  // With LATENCY==1 the access happens on the accept edge itself
  always_comb begin
    c_wr   = wr_q;
    c_sz   = sz_q;
    c_uns  = uns_q;
    c_addr = addr_q;
    c_wd   = wd_q;
    if (state_q == IDLE) begin
      c_wr   = req_write;
      c_sz   = req_size;
      c_uns  = req_unsigned;
      c_addr = req_addr;
      c_wd   = req_wdata;
    end
  end

  assign c_ok  = {2'b00, c_addr[31:2]} < 32'(DEPTH);
  assign c_err = (c_sz == 2'd3)
              || ((c_sz == 2'd1) && c_addr[0])
              || ((c_sz == 2'd2) && (c_addr[1:0] != 2'd0))
              || !c_ok;
  assign idx   = c_addr[2 +: IW];
  assign word  = c_ok ? mem[idx] : 32'd0;
  assign ld_b  = word[{c_addr[1:0], 3'b000} +: 8];
  assign ld_h  = c_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (c_sz)
      2'd0: ld = c_uns ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'd1: ld = c_uns ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld = word;
    endcase
  end

  always_comb begin
    wr_word = word;
    for (int k = 0; k < 4; k++) begin
      case (c_sz)
        2'd0: if (c_addr[1:0] == 2'(k))
          wr_word[8*k +: 8] = c_wd[7:0];
        2'd1: if (c_addr[1] == k[1])
          wr_word[8*k +: 8] = c_wd[8*(k%2) +: 8];
        default: wr_word[8*k +: 8] = c_wd[8*k +: 8];
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    unique case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      sz_q    <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= 4'(LATENCY - 1);
        wr_q   <= req_write;
        sz_q   <= req_size;
        uns_q  <= req_unsigned;
        addr_q <= req_addr;
        wd_q   <= req_wdata;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fire) begin
        rdata_q <= (c_err || c_wr) ? 32'd0 : ld;
        err_q   <= c_err;
      end
    end
  end

  // Array is not reset; a store aborted by reset never reaches it
  always_ff @(posedge clk) begin
    if (rst && fire && c_wr && !c_err) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH=128, LATENCY=2).
// Hand-computed expectations for loads, stores, errors and reset abort.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_vec = 0;
  int n_err = 0;

  data_mem_ctrl #(.DEPTH(128), .LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    resp_ready   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic e;
    int l;
    xact(1'b0, sz, u, a, 32'd0, d, e, l);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  task automatic wr_chk(input string tag, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_e);
    logic [31:0] d;
    logic e;
    int l;
    xact(1'b1, sz, 1'b0, a, wd, d, e, l);
    chk({tag, "_data"}, d, 32'd0);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  logic [31:0] d;
  logic        e;
  int          l;

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // 1: latency and plain word load
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, d, e, l);
    chk("lw10_lat", 32'(l), 32'd2);
    chk("lw10_data", d, 32'h4);
    chk("lw10_err", {31'd0, e}, 32'd0);

    // 2: byte store, then extended byte loads
    wr_chk("sb21", 2'd0, 32'h21, 32'h000000AB, 1'b0);
    rd_chk("lw20", 2'd2, 1'b0, 32'h20, 32'h0000AB08, 1'b0);
    rd_chk("lb21", 2'd0, 1'b0, 32'h21, 32'hFFFFFFAB, 1'b0);
    rd_chk("lbu21", 2'd0, 1'b1, 32'h21, 32'h000000AB, 1'b0);

    // 3: half store/loads and misalignment
    wr_chk("sh22", 2'd1, 32'h22, 32'h00008001, 1'b0);
    rd_chk("lh22", 2'd1, 1'b0, 32'h22, 32'hFFFF8001, 1'b0);
    rd_chk("lhu22", 2'd1, 1'b1, 32'h22, 32'h00008001, 1'b0);
    rd_chk("lh20", 2'd1, 1'b0, 32'h20, 32'hFFFFAB08, 1'b0);
    rd_chk("lb23", 2'd0, 1'b0, 32'h23, 32'hFFFFFF80, 1'b0);
    rd_chk("lw06", 2'd2, 1'b0, 32'h06, 32'h0, 1'b1);
    rd_chk("lh21", 2'd1, 1'b0, 32'h21, 32'h0, 1'b1);
    wr_chk("sw03", 2'd2, 32'h03, 32'h12345678, 1'b1);
    rd_chk("lw00", 2'd2, 1'b0, 32'h00, 32'h0, 1'b0);

    // 4: back-pressure held in RESP
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    l = 0;
    while (!resp_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    chk("bp_lat", 32'(l), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_rdata, 32'h4);
      chk("bp_err", 32'(resp_err), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      req_valid = (i == 2);
      req_write = 1'b1;
      req_wdata = 32'hFFFFFFFF;
    end
    req_valid  = 1'b0;
    req_write  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("bp_drop", 32'(resp_valid), 32'd0);
    chk("bp_idle", 32'(req_ready), 32'd1);
    rd_chk("bp_mem", 2'd2, 1'b0, 32'h10, 32'h4, 1'b0);

    // 5: range and size errors, top word boundary
    rd_chk("lw200", 2'd2, 1'b0, 32'h200, 32'h0, 1'b1);
    wr_chk("sw200", 2'd2, 32'h200, 32'h1, 1'b1);
    wr_chk("sz3", 2'd3, 32'h10, 32'h55, 1'b1);
    rd_chk("sz3_mem", 2'd2, 1'b0, 32'h10, 32'h4, 1'b0);
    rd_chk("lw1fc", 2'd2, 1'b0, 32'h1FC, 32'h7F, 1'b0);
    wr_chk("sb1ff", 2'd0, 32'h1FF, 32'hC3, 1'b0);
    rd_chk("lw1fc2", 2'd2, 1'b0, 32'h1FC, 32'hC300007F, 1'b0);

    // 6: reset during WAIT aborts the store
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h40;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    chk("abort_wait", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid0", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_quiet", 32'(resp_valid), 32'd0);
    rd_chk("lw40", 2'd2, 1'b0, 32'h40, 32'h10, 1'b0);
    rd_chk("lw20_kept", 2'd2, 1'b0, 32'h20, 32'h8001AB08, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
